alu_seq: RTL



---
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Multi-cycle integer ALU: add/sub in one cycle, shift-add multiply and restoring divide over WIDTH cycles.
// Optional macro ALU_SEQ_REM_EN keeps a division remainder register; otherwise Remainder is tied to 0.
module alu_seq #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Remainder,
  output logic             Carry,
  output logic             OverFlow,
  output logic             Zero,
  output logic             Negative,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Handshake: start is taken on any edge where busy=0 (IDLE or DONE);
  // done is a one-cycle pulse and Result/flags hold until the next done.

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             div_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;

  logic [WIDTH:0]   msum, shifted, add_w, sub_w;
  logic [WIDTH-1:0] diff, step_hi, step_lo;
  logic             div_ge;

  logic             iter_load, load_out;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c, fin_v;

  // hi:lo is the double-width product (mul) or remainder:quotient pair (div).
  always_comb begin
    msum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    div_ge  = shifted >= {1'b0, b_q};
    diff    = shifted[WIDTH-1:0] - b_q;
    if (div_q) begin
      step_hi = div_ge ? diff : shifted[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = msum[WIDTH:1];
      step_lo = {msum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    add_w = {1'b0, A} + {1'b0, B};
    sub_w = {1'b0, A} - {1'b0, B};
  end

  always_comb begin
    state_d   = state_q;
    iter_load = 1'b0;
    load_out  = 1'b0;
    fin_res   = '0;
    fin_c     = 1'b0;
    fin_v     = 1'b0;
    case (state_q)
      S_ITER: begin
        if (cnt_q == CNT_ONE) begin
          state_d  = S_DONE;
          load_out = 1'b1;
          fin_res  = step_lo;
          fin_v    = div_q ? 1'b0 : (|step_hi);
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          case (ALUControl)
            OP_ADD: begin
              state_d  = S_DONE;
              load_out = 1'b1;
              fin_res  = add_w[WIDTH-1:0];
              fin_c    = add_w[WIDTH];
              fin_v    = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
              state_d  = S_DONE;
              load_out = 1'b1;
              fin_res  = sub_w[WIDTH-1:0];
              fin_c    = ~sub_w[WIDTH];
              fin_v    = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_MUL: begin
              state_d   = S_ITER;
              iter_load = 1'b1;
            end
            default: begin
              if (B == '0) begin
                state_d  = S_DONE;
                load_out = 1'b1;
                fin_res  = '1;
                fin_v    = 1'b1;
              end else begin
                state_d   = S_ITER;
                iter_load = 1'b1;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      Result   <= '0;
      Carry    <= 1'b0;
      OverFlow <= 1'b0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
    end else begin
      state_q <= state_d;
      if (iter_load) begin
        cnt_q <= CNT_LOAD;
        a_q   <= A;
        b_q   <= B;
        div_q <= ALUControl[0];
        hi_q  <= '0;
        lo_q  <= ALUControl[0] ? A : B;
      end else if (state_q == S_ITER) begin
        cnt_q <= cnt_q - CNT_ONE;
        hi_q  <= step_hi;
        lo_q  <= step_lo;
      end
      if (load_out) begin
        Result   <= fin_res;
        Carry    <= fin_c;
        OverFlow <= fin_v;
        Zero     <= (fin_res == '0);
        Negative <= fin_res[WIDTH-1];
      end
    end
  end

`ifdef ALU_SEQ_REM_EN
  logic [WIDTH-1:0] rem_q, fin_rem;

  // Only a finished divide (or divide-by-zero, which returns A) leaves a non-zero remainder.
  always_comb begin
    fin_rem = '0;
    if (state_q == S_ITER) begin
      fin_rem = div_q ? step_hi : '0;
    end else if (ALUControl == OP_DIV) begin
      fin_rem = A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
    end else if (load_out) begin
      rem_q <= fin_rem;
    end
  end

  assign Remainder = rem_q;
`else
  assign Remainder = '0;
`endif

  assign busy      = (state_q == S_ITER);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule
